// File: rtl/pe_act_queue.sv
// Per-PE activation FIFO between the router network interface and the PE FSM.
// Optional build macro PE_ACT_QUEUE_ZERO_SKIP_EN discards zero-valued packets.
module pe_act_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 6,
  parameter int DEPTH      = 8,
  parameter int AFULL_TH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_en,
  input  logic [IDX_WIDTH-1:0]          push_idx,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          flush,
  input  logic                          pop_act,
  output logic                          queue_empty,
  output logic                          queue_full,
  output logic                          queue_afull,
  output logic [IDX_WIDTH+DATA_WIDTH-1:0] act_out,
  output logic [$clog2(DEPTH):0]        q_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IDX_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_TH);

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_req, do_push, do_pop, drop;

`ifdef PE_ACT_QUEUE_ZERO_SKIP_EN
  // Zero activations contribute nothing to the MAC, so they never occupy a slot.
  assign push_req = push_en && (push_data != '0);
`else
  assign push_req = push_en;
`endif

  assign do_pop  = pop_act && (count != '0);
  assign do_push = push_req && ((count != DEPTH_C) || do_pop);
  assign drop    = push_req && (count == DEPTH_C) && !do_pop;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates visibility,
  // so stale contents are never observable and the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= {push_idx, push_data};
  end

  assign queue_empty = (count == '0);
  assign queue_full  = (count == DEPTH_C);
  assign queue_afull = ((DEPTH_C - count) <= AFULL_C);
  assign q_count     = count;
  assign act_out     = queue_empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_pe_act_queue.sv
// Scoreboard bench for pe_act_queue: stimulus queues expected entries, a
// negedge monitor compares act_out whenever the FSM retires a head entry.
module tb_pe_act_queue;

  localparam int DW = 16;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_en = 1'b0;
  logic [IW-1:0] push_idx = '0;
  logic [DW-1:0] push_data = '0;
  logic          flush = 1'b0;
  logic          pop_act = 1'b0;
  logic          queue_empty, queue_full, queue_afull, overflow;
  logic [IW+DW-1:0] act_out;
  logic [3:0]    q_count;

  int tests = 0;
  int fails = 0;
  logic [IW+DW-1:0] exp_q[$];

  pe_act_queue dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_idx(push_idx),
    .push_data(push_data), .flush(flush), .pop_act(pop_act),
    .queue_empty(queue_empty), .queue_full(queue_full),
    .queue_afull(queue_afull), .act_out(act_out), .q_count(q_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: an accepted pop retires the head, which must match the scoreboard.
  always @(negedge clk) begin
    if (rst && pop_act && !flush && !queue_empty) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h expected no entry", act_out);
      end else begin
        logic [IW+DW-1:0] e;
        e = exp_q.pop_front();
        if (act_out !== e) begin
          fails++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", act_out, e);
        end
      end
    end
  end

  task automatic cyc(input logic pe, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                     input logic pp, input logic fl);
    push_en = pe; push_idx = idx; push_data = data; pop_act = pp; flush = fl;
    @(posedge clk); #1;
    push_en = 1'b0; pop_act = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic [DW-1:0] data, input logic accept);
    cyc(1'b1, idx, data, 1'b0, 1'b0);
    if (accept) exp_q.push_back({idx, data});
  endtask

  task automatic pop();
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(queue_empty), 32'd1);
    check({tag, "_full"},  32'(queue_full),  32'd0);
    check({tag, "_afull"}, 32'(queue_afull), 32'd0);
    check({tag, "_count"}, 32'(q_count),     32'd0);
    check({tag, "_act"},   32'(act_out),     32'd0);
    check({tag, "_ovf"},   32'(overflow),    32'd0);
  endtask

  initial begin
    // Reset
    #12;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 1. three pushes, in-order drain
    push(6'd1, 16'h0011, 1'b1);
    push(6'd2, 16'h0022, 1'b1);
    push(6'd3, 16'h0033, 1'b1);
    check("t1_count", 32'(q_count), 32'd3);
    check("t1_head",  32'(act_out), 32'({6'd1, 16'h0011}));
    check("t1_empty", 32'(queue_empty), 32'd0);
    for (int i = 0; i < 3; i++) pop();
    check("t1_empty_after", 32'(queue_empty), 32'd1);
    check("t1_act_zero", 32'(act_out), 32'd0);

    // Realign pointers to slot 0 so the wrap in test 3 lands at wr_ptr 0
    cyc(1'b0, '0, '0, 1'b0, 1'b1);

    // 2. nine pushes, no pops
    for (int i = 0; i < 9; i++) begin
      int c;
      push(6'(10 + i), 16'(16'h0100 + i), i < 8);
      c = (i + 1 > 8) ? 8 : i + 1;
      check("t2_count", 32'(q_count), 32'(c));
      check("t2_afull", 32'(queue_afull), 32'(c >= 6));
      check("t2_full",  32'(queue_full), 32'(c == 8));
    end
    check("t2_overflow", 32'(overflow), 32'd1);
    check("t2_head", 32'(act_out), 32'({6'd10, 16'h0100}));

    // 3. full, push+pop together
    cyc(1'b1, 6'd20, 16'h0200, 1'b1, 1'b0);
    exp_q.push_back({6'd20, 16'h0200});
    check("t3_count", 32'(q_count), 32'd8);
    check("t3_head", 32'(act_out), 32'({6'd11, 16'h0101}));
    for (int i = 0; i < 8; i++) pop();
    check("t3_empty", 32'(queue_empty), 32'd1);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4. pop on empty is ignored; push+pop on empty keeps the push
    pop();
    check("t4_pop_empty_count", 32'(q_count), 32'd0);
    check("t4_pop_empty_flag", 32'(queue_empty), 32'd1);
    cyc(1'b1, 6'd30, 16'h0300, 1'b1, 1'b0);
    exp_q.push_back({6'd30, 16'h0300});
    check("t4_count", 32'(q_count), 32'd1);
    check("t4_head", 32'(act_out), 32'({6'd30, 16'h0300}));
    pop();

    // 5. flush beats simultaneous push/pop, then async reset mid-burst
    for (int i = 0; i < 5; i++) push(6'(40 + i), 16'(16'h0400 + i), 1'b1);
    check("t5_count_pre", 32'(q_count), 32'd5);
    cyc(1'b1, 6'd45, 16'h0405, 1'b1, 1'b1);
    exp_q.delete();
    check("t5_flush_count", 32'(q_count), 32'd0);
    check("t5_flush_empty", 32'(queue_empty), 32'd1);
    check("t5_flush_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) push(6'(50 + i), 16'(16'h0500 + i), 1'b1);
    push_en = 1'b1; push_idx = 6'd60; push_data = 16'h0600;
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("t5_async");
    push_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_post_reset_count", 32'(q_count), 32'd0);

    // 6. zero-valued packets
`ifdef PE_ACT_QUEUE_ZERO_SKIP_EN
    push(6'd1, 16'h0000, 1'b0);
    push(6'd2, 16'h0005, 1'b1);
    push(6'd3, 16'h0000, 1'b0);
    check("t6_count", 32'(q_count), 32'd1);
    check("t6_head", 32'(act_out), 32'({6'd2, 16'h0005}));
    pop();
`else
    push(6'd1, 16'h0000, 1'b1);
    push(6'd2, 16'h0005, 1'b1);
    push(6'd3, 16'h0000, 1'b1);
    check("t6_count", 32'(q_count), 32'd3);
    check("t6_head", 32'(act_out), 32'({6'd1, 16'h0000}));
    for (int i = 0; i < 3; i++) pop();
`endif
    check("t6_empty", 32'(queue_empty), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
